fifo_drain_demux: RTL and testbench

Downstream consumer of the 6-bit data FIFO. Pops words from the FIFO whenever it holds data and the downstream path can accept it. Routes each word to one of four destination queues selected by its top two bits. Absorbs the FIFO's one-cycle read latency and downstream backpressure with a 2-entry in-order hold buffer, and keeps a per-destination delivered-word count.

---
 rtl/fifo_drain_demux.sv | 163 ++++++++++++++++
 tb/tb_fifo_drain_demux.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_demux.sv
// Purpose : drains the upstream data FIFO and steers each word to one of four
//           destination queues chosen by its top two bits, counting deliveries.
// Latency : Fifo_rd in cycle N -> push/data_out valid in cycle N+2 when unblocked.
// Backpr. : dest_full stalls reads; a 2-entry in-order hold buffer absorbs the
//           word already in flight; a blocked head stalls everything behind it.
//
// Ports:
//   clk, reset         clock; asynchronous active-low reset
//   enable             permits new FIFO reads
//   Fifo_empty         upstream FIFO empty flag
//   Fifo_Data_out      upstream read data, qualified by valid_read
//   valid_read         Fifo_Data_out carries a popped word this cycle
//   dest_full          per-destination almost-full (bit d = destination d)
//   Fifo_rd            combinational pop request to the upstream FIFO
//   data_out, push     registered delivered word and one-hot write strobe
//   hold_cnt           hold buffer occupancy (0..2)
//   pkt_cnt            per-destination delivered-word counters, wrapping
module fifo_drain_demux #(
  parameter int BITNUMBER = 6,
  parameter int CNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   Fifo_empty,
  input  logic [BITNUMBER-1:0]   Fifo_Data_out,
  input  logic                   valid_read,
  input  logic [3:0]             dest_full,
  output logic                   Fifo_rd,
  output logic [BITNUMBER-1:0]   data_out,
  output logic [3:0]             push,
  output logic [1:0]             hold_cnt,
  output logic [4*CNT_WIDTH-1:0] pkt_cnt
);

  // IDLE/RUN are informational; HOLD is exactly "hold buffer non-empty" and
  // is what the datapath uses to decide between direct and buffered delivery.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t               state_q;
  state_t               state_nxt;

  // hold0_q is the head (oldest word), hold1_q the tail.
  logic [BITNUMBER-1:0] hold0_q;
  logic [BITNUMBER-1:0] hold1_q;
  logic [BITNUMBER-1:0] hold0_nxt;
  logic [BITNUMBER-1:0] hold1_nxt;
  logic [1:0]           cnt_nxt;

  logic                 buf_busy;
  logic [1:0]           arr_dest;
  logic [1:0]           head_dest;

  logic                 dlv_vld;
  logic [BITNUMBER-1:0] dlv_dat;
  logic [1:0]           dlv_dest;
  logic [3:0]           dlv_onehot;

  logic [CNT_WIDTH-1:0] cnt_q [4];

  assign arr_dest  = Fifo_Data_out[BITNUMBER-1 -: 2];
  assign head_dest = hold0_q[BITNUMBER-1 -: 2];
  assign buf_busy  = (state_q == HOLD);

  // Reads stop as soon as anything is buffered or any destination is nearly
  // full, so at most one more word can already be in flight -> depth 2 suffices.
  // The reset term keeps the pop request quiet while reset is held.
  assign Fifo_rd = reset & enable & ~Fifo_empty & (hold_cnt == 2'd0)
                 & (dest_full == 4'b0000);

  // Delivery selection and hold buffer update. The head drains first; an
  // arriving word is then delivered directly only if nothing was buffered,
  // otherwise it joins the tail behind whatever remains.
  always_comb begin
    dlv_vld   = 1'b0;
    dlv_dat   = '0;
    hold0_nxt = hold0_q;
    hold1_nxt = hold1_q;
    cnt_nxt   = hold_cnt;

    if (buf_busy && !dest_full[head_dest]) begin
      dlv_vld   = 1'b1;
      dlv_dat   = hold0_q;
      hold0_nxt = hold1_q;
      cnt_nxt   = hold_cnt - 2'd1;
    end

    if (valid_read) begin
      if (!buf_busy && !dest_full[arr_dest]) begin
        dlv_vld = 1'b1;
        dlv_dat = Fifo_Data_out;
      end else if (cnt_nxt == 2'd0) begin
        hold0_nxt = Fifo_Data_out;
        cnt_nxt   = 2'd1;
      end else if (cnt_nxt == 2'd1) begin
        hold1_nxt = Fifo_Data_out;
        cnt_nxt   = 2'd2;
      end
      // A third word with a full, blocked buffer is an upstream protocol
      // violation; it is dropped and never counted.
    end
  end

  assign dlv_dest   = dlv_dat[BITNUMBER-1 -: 2];
  assign dlv_onehot = 4'b0001 << dlv_dest;

  // Mode tracking: HOLD mirrors the next buffer occupancy, so HOLD falls back
  // to RUN/IDLE in the cycle after the last entry drains.
  always_comb begin
    state_nxt = state_q;
    if (cnt_nxt != 2'd0) begin
      state_nxt = HOLD;
    end else if (Fifo_rd || valid_read) begin
      state_nxt = RUN;
    end else begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      hold_cnt <= 2'd0;
      hold0_q  <= '0;
      hold1_q  <= '0;
      push     <= 4'b0000;
      data_out <= '0;
    end else begin
      state_q  <= state_nxt;
      hold_cnt <= cnt_nxt;
      hold0_q  <= hold0_nxt;
      hold1_q  <= hold1_nxt;
      push     <= dlv_vld ? dlv_onehot : 4'b0000;
      if (dlv_vld) begin
        data_out <= dlv_dat;
      end
    end
  end

  // Delivered-word counters, wrapping naturally at 2^CNT_WIDTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int d = 0; d < 4; d++) begin
        cnt_q[d] <= '0;
      end
    end else begin
      for (int d = 0; d < 4; d++) begin
        if (dlv_vld && (dlv_dest == d[1:0])) begin
          cnt_q[d] <= cnt_q[d] + CNT_WIDTH'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_pkt_cnt
    assign pkt_cnt[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
  end

endmodule

// File: tb/tb_fifo_drain_demux.sv
// Directed bench for fifo_drain_demux: streaming, backpressure, head-of-line
// blocking, overflow drop, counter wrap, async reset and enable drop.
module tb_fifo_drain_demux;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        Fifo_empty;
  logic [5:0]  Fifo_Data_out;
  logic        valid_read;
  logic [3:0]  dest_full;
  logic        Fifo_rd;
  logic [5:0]  data_out;
  logic [3:0]  push;
  logic [1:0]  hold_cnt;
  logic [31:0] pkt_cnt;

  int          n_assert;
  int          n_fail;
  logic        rd;
  logic [5:0]  fq [$];

  logic        e_rd   [6];
  logic [3:0]  e_push [6];
  logic [5:0]  e_dat  [6];

  fifo_drain_demux #(.BITNUMBER(6), .CNT_WIDTH(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .Fifo_empty    (Fifo_empty),
    .Fifo_Data_out (Fifo_Data_out),
    .valid_read    (valid_read),
    .dest_full     (dest_full),
    .Fifo_rd       (Fifo_rd),
    .data_out      (data_out),
    .push          (push),
    .hold_cnt      (hold_cnt),
    .pkt_cnt       (pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock with inputs driven directly by the sequence.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One clock with the upstream FIFO modelled: a pop requested before the
  // edge shows up with valid_read in the following cycle.
  task automatic cyc_fifo(output logic r);
    @(negedge clk);
    r = Fifo_rd;
    @(posedge clk);
    #1;
    if (r && fq.size() > 0) begin
      valid_read    = 1'b1;
      Fifo_Data_out = fq.pop_front();
    end else begin
      valid_read = 1'b0;
    end
    Fifo_empty = (fq.size() == 0);
  endtask

  initial begin
    n_assert      = 0;
    n_fail        = 0;
    reset         = 1'b0;
    enable        = 1'b1;
    Fifo_empty    = 1'b0;
    Fifo_Data_out = 6'h00;
    valid_read    = 1'b0;
    dest_full     = 4'b0000;

    // ---- reset state (pop request suppressed even with enable and data)
    #12;
    check("rst_push",    32'(push),     32'h0);
    check("rst_data",    32'(data_out), 32'h0);
    check("rst_hold",    32'(hold_cnt), 32'h0);
    check("rst_pkt",     pkt_cnt,       32'h0);
    check("rst_fifo_rd", 32'(Fifo_rd),  32'h0);
    Fifo_empty = 1'b1;
    enable     = 1'b0;
    cyc();
    reset = 1'b1;

    // ---- stream of four words, one per destination
    e_rd   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    e_push = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0};
    e_dat  = '{6'h00, 6'h05, 6'h13, 6'h2A, 6'h3F, 6'h00};
    fq.push_back(6'h05);
    fq.push_back(6'h13);
    fq.push_back(6'h2A);
    fq.push_back(6'h3F);
    Fifo_empty = 1'b0;
    enable     = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc_fifo(rd);
      check("stream_rd",   32'(rd),   32'(e_rd[k]));
      check("stream_push", 32'(push), 32'(e_push[k]));
      if (e_push[k] != 4'h0) check("stream_data", 32'(data_out), 32'(e_dat[k]));
    end
    check("stream_pkt", pkt_cnt, 32'h01010101);
    enable = 1'b0;

    // ---- backpressure: both words land in the hold buffer
    dest_full  = 4'b0100;
    enable     = 1'b1;
    Fifo_empty = 1'b0;
    #2;
    check("bp_rd_full", 32'(Fifo_rd), 32'h0);
    valid_read = 1'b1; Fifo_Data_out = 6'h21;
    cyc();
    check("bp_hold1", 32'(hold_cnt), 32'h1);
    check("bp_push1", 32'(push),     32'h0);
    Fifo_Data_out = 6'h02;
    cyc();
    check("bp_hold2", 32'(hold_cnt), 32'h2);
    check("bp_push2", 32'(push),     32'h0);
    valid_read = 1'b0;
    dest_full  = 4'b0000;
    #2;
    check("bp_rd_hold", 32'(Fifo_rd), 32'h0);
    Fifo_empty = 1'b1;
    cyc();
    check("bp_push_a", 32'(push),     32'h4);
    check("bp_data_a", 32'(data_out), 32'h21);
    check("bp_hold_a", 32'(hold_cnt), 32'h1);
    cyc();
    check("bp_push_b", 32'(push),     32'h1);
    check("bp_data_b", 32'(data_out), 32'h02);
    check("bp_hold_b", 32'(hold_cnt), 32'h0);
    cyc();
    check("bp_push_c", 32'(push), 32'h0);
    check("bp_pkt",    pkt_cnt,   32'h01020102);
    enable = 1'b0;

    // ---- head-of-line blocking, plus an illegal third word that is dropped
    dest_full  = 4'b1000;
    valid_read = 1'b1; Fifo_Data_out = 6'h30;
    cyc();
    Fifo_Data_out = 6'h01;
    cyc();
    check("hol_hold2", 32'(hold_cnt), 32'h2);
    check("hol_push0", 32'(push),     32'h0);
    Fifo_Data_out = 6'h3F;
    cyc();
    check("ovf_hold", 32'(hold_cnt), 32'h2);
    check("ovf_push", 32'(push),     32'h0);
    valid_read = 1'b0;
    cyc();
    check("hol_still", 32'(push), 32'h0);
    dest_full = 4'b0000;
    cyc();
    check("hol_push_a", 32'(push),     32'h8);
    check("hol_data_a", 32'(data_out), 32'h30);
    cyc();
    check("hol_push_b", 32'(push),     32'h1);
    check("hol_data_b", 32'(data_out), 32'h01);
    cyc();
    check("hol_push_c", 32'(push),     32'h0);
    check("hol_hold0",  32'(hold_cnt), 32'h0);
    check("hol_pkt",    pkt_cnt,       32'h02020103);

    // ---- simultaneous drain and arrival keeps occupancy constant
    dest_full  = 4'b0001;
    valid_read = 1'b1; Fifo_Data_out = 6'h02;
    cyc();
    dest_full = 4'b0000;
    Fifo_Data_out = 6'h13;
    cyc();
    check("sim_push_a", 32'(push),     32'h1);
    check("sim_data_a", 32'(data_out), 32'h02);
    check("sim_hold",   32'(hold_cnt), 32'h1);
    valid_read = 1'b0;
    cyc();
    check("sim_push_b", 32'(push),     32'h2);
    check("sim_data_b", 32'(data_out), 32'h13);
    check("sim_pkt",    pkt_cnt,       32'h02020204);

    // ---- asynchronous reset in HOLD, asserted between edges
    dest_full  = 4'b0100;
    valid_read = 1'b1; Fifo_Data_out = 6'h21;
    cyc();
    Fifo_Data_out = 6'h05;
    cyc();
    valid_read = 1'b0;
    dest_full  = 4'b0000;
    cyc();
    check("ar_pre_push", 32'(push),     32'h4);
    check("ar_pre_hold", 32'(hold_cnt), 32'h1);
    #3;
    reset = 1'b0;
    #1;
    check("ar_push", 32'(push),     32'h0);
    check("ar_hold", 32'(hold_cnt), 32'h0);
    check("ar_pkt",  pkt_cnt,       32'h0);
    check("ar_data", 32'(data_out), 32'h0);
    enable     = 1'b1;
    Fifo_empty = 1'b0;
    #1;
    check("ar_rd", 32'(Fifo_rd), 32'h0);
    cyc();
    check("ar_rd_edge", 32'(Fifo_rd),  32'h0);
    check("ar_hold_e",  32'(hold_cnt), 32'h0);
    Fifo_empty = 1'b1;
    enable     = 1'b0;
    reset      = 1'b1;

    // ---- counter wrap on destination 1
    valid_read = 1'b1; Fifo_Data_out = 6'h15;
    for (int k = 0; k < 255; k++) cyc();
    check("wrap_255",  pkt_cnt,           32'h0000FF00);
    check("wrap_push", 32'(push),         32'h2);
    check("wrap_data", 32'(data_out),     32'h15);
    cyc();
    check("wrap_256",  pkt_cnt,           32'h0);
    valid_read = 1'b0;
    cyc();
    check("wrap_idle", 32'(push), 32'h0);

    // ---- enable drop right after a read
    fq.push_back(6'h3A);
    fq.push_back(6'h11);
    fq.push_back(6'h2C);
    Fifo_empty = 1'b0;
    enable     = 1'b1;
    cyc_fifo(rd);
    check("en_rd1", 32'(rd), 32'h1);
    enable = 1'b0;
    #2;
    check("en_rd_off", 32'(Fifo_rd), 32'h0);
    cyc_fifo(rd);
    check("en_rd2",    32'(rd),       32'h0);
    check("en_push_a", 32'(push),     32'h8);
    check("en_data_a", 32'(data_out), 32'h3A);
    cyc_fifo(rd);
    check("en_rd3",  32'(rd),   32'h0);
    check("en_push", 32'(push), 32'h0);
    cyc_fifo(rd);
    check("en_rd4", 32'(rd), 32'h0);
    enable = 1'b1;
    cyc_fifo(rd);
    check("en_rd5",    32'(rd),   32'h1);
    check("en_push_b", 32'(push), 32'h0);
    cyc_fifo(rd);
    check("en_rd6",    32'(rd),       32'h1);
    check("en_push_c", 32'(push),     32'h2);
    check("en_data_c", 32'(data_out), 32'h11);
    cyc_fifo(rd);
    check("en_rd7",    32'(rd),       32'h0);
    check("en_push_d", 32'(push),     32'h4);
    check("en_data_d", 32'(data_out), 32'h2C);
    cyc_fifo(rd);
    check("en_push_e", 32'(push), 32'h0);
    check("en_pkt",    pkt_cnt,   32'h01010100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
